decode_stage_ctrl: RTL

Decode-stage controller for the RV32I pipeline. It holds the fetched instruction and drives the select input of the shared immediate extender. It captures the extended immediate into the ID/EX register with a valid/ready handshake. It detects load-use hazards and inserts one bubble, and applies branch flushes from execute.

---
 rtl/decode_stage_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: RV32I decode holding register with immediate-select drive,
// ID/EX capture over a valid/ready handshake, load-use bubble insertion and branch flush.
module decode_stage_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             flush,
    output logic [1:0]       imm_src,
    input  logic [31:0]      imm_ext_in,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [31:0]      ex_instr,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_mem_read,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {EMPTY, HELD, STALL} state_t;

    state_t           state;
    logic             d_valid_q, d_valid_d;
    logic [31:0]      d_instr_q, d_instr_d;
    logic             ex_valid_q, ex_valid_d;
    logic [31:0]      ex_instr_q, ex_instr_d;
    logic [31:0]      ex_imm_q, ex_imm_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       uses_rs2, hazard, e_free, advance, accept;

    assign opcode   = d_instr_q[6:0];
    assign rs1      = d_instr_q[19:15];
    assign rs2      = d_instr_q[24:20];
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign hazard   = d_valid_q && ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                      ((ex_rd_q == rs1) || (uses_rs2 && (ex_rd_q == rs2)));
    assign e_free   = !ex_valid_q || ex_ready;
    assign advance  = d_valid_q && e_free && !hazard && !flush;
    assign instr_ready = !flush && (!d_valid_q || advance);
    assign accept   = instr_valid && instr_ready;

    assign imm_src = !d_valid_q ? 2'b11 :
                     ((opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_JALR)) ? 2'b00 :
                     (opcode == OP_STORE) ? 2'b01 : 2'b11;

    assign state = !d_valid_q ? EMPTY : (hazard ? STALL : HELD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid_q     <= 1'b0;
            d_instr_q     <= '0;
            ex_valid_q    <= 1'b0;
            ex_instr_q    <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_mem_read_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            d_valid_q     <= d_valid_d;
            d_instr_q     <= d_instr_d;
            ex_valid_q    <= ex_valid_d;
            ex_instr_q    <= ex_instr_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_mem_read_q <= ex_mem_read_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        d_valid_d     = d_valid_q;
        d_instr_d     = accept ? instr_in : d_instr_q;
        ex_valid_d    = ex_valid_q;
        ex_instr_d    = ex_instr_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_mem_read_d = ex_mem_read_q;
        cnt_d         = cnt_q;
        case (state)
            EMPTY: d_valid_d = accept;
            HELD: begin
                if (advance) begin
                    ex_valid_d    = 1'b1;
                    ex_instr_d    = d_instr_q;
                    ex_imm_d      = imm_ext_in;
                    ex_rd_d       = d_instr_q[11:7];
                    ex_mem_read_d = (opcode == OP_LOAD);
                    d_valid_d     = accept;
                end
            end
            STALL: begin
                if (e_free) begin
                    ex_valid_d = 1'b0;
                    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: d_valid_d = 1'b0;
        endcase
        if (ex_valid_q && ex_ready && !advance && !hazard)
            ex_valid_d = 1'b0;
        // flush outranks everything, including a bubble that would otherwise be counted
        if (flush) begin
            d_valid_d  = 1'b0;
            ex_valid_d = 1'b0;
            cnt_d      = cnt_q;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_instr    = ex_instr_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_mem_read = ex_mem_read_q;
    assign stall_cnt   = cnt_q;
endmodule
